// File: rtl/sram_layer1_set_ctrl_if.sv
// Host/engine-facing bus of the layer-1 weight SRAM set controller, plus its
// port1 bus toward the SRAM set. The controller connects through the slave modport.
interface sram_layer1_set_ctrl_if #(
    parameter int BIT_WIDTH_SRAM    = 160,
    parameter int BIT_WIDTH_ADDRESS = 10,
    parameter int SET_NUM           = 10
);
    // Weight loader
    logic                                  load_start_i;
    logic                                  wr_valid_i;
    logic [BIT_WIDTH_SRAM-1:0]             wr_data_i;
    logic                                  wr_ready_o;
    logic                                  load_done_o;
    logic                                  loaded_o;

    // Broadcast read port
    logic                                  rd_valid_i;
    logic [BIT_WIDTH_ADDRESS-1:0]          rd_addr_i;
    logic                                  rd_ready_o;
    logic                                  rd_data_valid_o;
    logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     rd_data_o;
    logic                                  rd_addr_err_o;

    // SRAM set port1
    logic [BIT_WIDTH_ADDRESS*SET_NUM-1:0]  port1_address_o;
    logic [SET_NUM-1:0]                    port1_enable_o;
    logic [SET_NUM-1:0]                    port1_write_enable_o;
    logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     port1_write_data_o;
    logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     port1_read_data_i;

    modport slave (
        input  load_start_i, wr_valid_i, wr_data_i, rd_valid_i, rd_addr_i, port1_read_data_i,
        output wr_ready_o, load_done_o, loaded_o, rd_ready_o, rd_data_valid_o, rd_data_o,
               rd_addr_err_o, port1_address_o, port1_enable_o, port1_write_enable_o,
               port1_write_data_o
    );

    modport master (
        output load_start_i, wr_valid_i, wr_data_i, rd_valid_i, rd_addr_i, port1_read_data_i,
        input  wr_ready_o, load_done_o, loaded_o, rd_ready_o, rd_data_valid_o, rd_data_o,
               rd_addr_err_o, port1_address_o, port1_enable_o, port1_write_enable_o,
               port1_write_data_o
    );
endinterface

// File: rtl/sram_layer1_set_ctrl.sv
// Load sequencer and broadcast-read controller for the layer-1 weight SRAM set.
// Define SRAM_L1_CTRL_OUTREG_EN to register the read response (latency 3 instead of 2).
module sram_layer1_set_ctrl #(
    parameter int BIT_WIDTH_SRAM    = 160,
    parameter int DEPTH_SRAM        = 980,
    parameter int BIT_WIDTH_ADDRESS = 10,
    parameter int SET_NUM           = 10
) (
    input logic                   clk,
    input logic                   reset,
    sram_layer1_set_ctrl_if.slave bus
);
    localparam int SET_W = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
    localparam int DW    = BIT_WIDTH_SRAM * SET_NUM;
    localparam int AWS   = BIT_WIDTH_ADDRESS * SET_NUM;
    localparam logic [BIT_WIDTH_ADDRESS-1:0] LAST_ADDR = BIT_WIDTH_ADDRESS'(DEPTH_SRAM - 1);
    localparam logic [SET_W-1:0]             LAST_SET  = SET_W'(SET_NUM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                       state_q, state_d;
    logic [SET_W-1:0]             set_cnt;
    logic [BIT_WIDTH_ADDRESS-1:0] addr_cnt;
    logic                         last_wr_q;
    logic                         load_done_q, load_done_d;

    logic                         wr_ready, wr_fire, rd_ready, rd_fire, rd_in_range;

    logic [SET_NUM-1:0]           p_en_d, p_en_q, p_we_d, p_we_q;
    logic [AWS-1:0]               p_addr_d, p_addr_q;
    logic [DW-1:0]                p_wdata_d, p_wdata_q;

    logic                         rd_v1, rd_err1, rd_v2, rd_err2;

    // Once the final word is taken, no more are accepted until READY or a restart.
    assign wr_ready    = (state_q == LOAD) && !last_wr_q && !bus.load_start_i;
    assign wr_fire     = wr_ready && bus.wr_valid_i;
    assign rd_ready    = (state_q == READY);
    assign rd_fire     = rd_ready && bus.rd_valid_i;
    assign rd_in_range = 32'(bus.rd_addr_i) < 32'(DEPTH_SRAM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            load_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of process evaluation order.
            state_q     <= state_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that leaves
        // one unassigned would infer a latch.
        state_d     = state_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE: if (bus.load_start_i) state_d = LOAD;
            LOAD: begin
                if (bus.load_start_i) begin
                    state_d = LOAD;
                end else if (last_wr_q) begin
                    state_d     = READY;
                    load_done_d = 1'b1;
                end
            end
            READY:   if (bus.load_start_i) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_cnt   <= '0;
            addr_cnt  <= '0;
            last_wr_q <= 1'b0;
        end else if (bus.load_start_i) begin
            set_cnt   <= '0;
            addr_cnt  <= '0;
            last_wr_q <= 1'b0;
        end else if (wr_fire) begin
            if (addr_cnt == LAST_ADDR) begin
                addr_cnt <= '0;
                if (set_cnt == LAST_SET) last_wr_q <= 1'b1;
                else                     set_cnt   <= set_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // Next port1 command: one-lane write, all-lane read, or idle with every lane zeroed.
    always_comb begin
        p_en_d    = '0;
        p_we_d    = '0;
        p_addr_d  = '0;
        p_wdata_d = '0;
        if (wr_fire) begin
            for (int i = 0; i < SET_NUM; i++) begin
                if (set_cnt == SET_W'(i)) begin
                    p_en_d[i] = 1'b1;
                    p_we_d[i] = 1'b1;
                    p_addr_d[BIT_WIDTH_ADDRESS*i +: BIT_WIDTH_ADDRESS] = addr_cnt;
                    p_wdata_d[BIT_WIDTH_SRAM*i +: BIT_WIDTH_SRAM]      = bus.wr_data_i;
                end
            end
        end else if (rd_fire && rd_in_range) begin
            p_en_d = '1;
            for (int i = 0; i < SET_NUM; i++) begin
                p_addr_d[BIT_WIDTH_ADDRESS*i +: BIT_WIDTH_ADDRESS] = bus.rd_addr_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_en_q    <= '0;
            p_we_q    <= '0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
        end else begin
            p_en_q    <= p_en_d;
            p_we_q    <= p_we_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
        end
    end

    // Stage 1 tracks the cycle port1 is driven, stage 2 the cycle SRAM data is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1   <= 1'b0;
            rd_err1 <= 1'b0;
            rd_v2   <= 1'b0;
            rd_err2 <= 1'b0;
        end else begin
            rd_v1   <= rd_fire;
            rd_err1 <= rd_fire && !rd_in_range;
            rd_v2   <= rd_v1;
            rd_err2 <= rd_err1;
        end
    end

`ifdef SRAM_L1_CTRL_OUTREG_EN
    logic          rd_valid_q, rd_err_q;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_v2;
            rd_err_q   <= rd_v2 && rd_err2;
            rd_data_q  <= (rd_v2 && !rd_err2) ? bus.port1_read_data_i : '0;
        end
    end

    assign bus.rd_data_valid_o = rd_valid_q;
    assign bus.rd_addr_err_o   = rd_err_q;
    assign bus.rd_data_o       = rd_data_q;
`else
    assign bus.rd_data_valid_o = rd_v2;
    assign bus.rd_addr_err_o   = rd_v2 && rd_err2;
    assign bus.rd_data_o       = (rd_v2 && !rd_err2) ? bus.port1_read_data_i : '0;
`endif

    assign bus.wr_ready_o           = wr_ready;
    assign bus.rd_ready_o           = rd_ready;
    assign bus.load_done_o          = load_done_q;
    assign bus.loaded_o             = (state_q == READY);
    assign bus.port1_enable_o       = p_en_q;
    assign bus.port1_write_enable_o = p_we_q;
    assign bus.port1_address_o      = p_addr_q;
    assign bus.port1_write_data_o   = p_wdata_q;
endmodule

// File: tb/tb_sram_layer1_set_ctrl.sv
// Self-checking bench: SRAM-set model on port1, table-driven reads through a
// scoreboard, and hand-written load/restart/reset sequences.
module tb_sram_layer1_set_ctrl;
    localparam int BW    = 160;
    localparam int DEPTH = 980;
    localparam int AW    = 10;
    localparam int SN    = 10;
    localparam int DW    = BW * SN;
    localparam int TOTAL = DEPTH * SN;
`ifdef SRAM_L1_CTRL_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int   addr;
        logic exp_err;
    } rd_vec_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t mon_e;
    int   mon_a;
    int   valid_cnt = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    logic done_loaded = 1'b0;

    logic [BW-1:0] mem [SN][DEPTH];
    rd_vec_t       vecs [6];

    sram_layer1_set_ctrl_if #(.BIT_WIDTH_SRAM(BW), .BIT_WIDTH_ADDRESS(AW), .SET_NUM(SN)) bus ();

    sram_layer1_set_ctrl #(
        .BIT_WIDTH_SRAM(BW), .DEPTH_SRAM(DEPTH), .BIT_WIDTH_ADDRESS(AW), .SET_NUM(SN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM set: one-cycle read latency, write-first not needed (port never mixes).
    always @(posedge clk) begin
        for (int i = 0; i < SN; i++) begin
            if (bus.port1_enable_o[i] === 1'b1) begin
                if (bus.port1_write_enable_o[i] === 1'b1)
                    mem[i][bus.port1_address_o[AW*i +: AW]] <= bus.port1_write_data_o[BW*i +: BW];
                else
                    bus.port1_read_data_i[BW*i +: BW] <= mem[i][bus.port1_address_o[AW*i +: AW]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] row_for(input int addr);
        logic [DW-1:0] r;
        for (int i = 0; i < SN; i++) r[BW*i +: BW] = BW'(DEPTH * i + addr);
        return r;
    endfunction

    function automatic logic [63:0] slice_mismatch(input logic [DW-1:0] a, input logic [DW-1:0] e);
        logic [63:0] m = '0;
        for (int i = 0; i < SN; i++) m[i] = (a[BW*i +: BW] !== e[BW*i +: BW]);
        return m;
    endfunction

    // Acceptance is recorded with the pre-edge cycle number.
    always @(posedge clk) begin
        if (reset === 1'b0 && bus.rd_valid_i === 1'b1 && bus.rd_ready_o === 1'b1)
            acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (bus.load_done_o === 1'b1) begin
            done_cnt++;
            done_cyc    = cyc;
            done_loaded = bus.loaded_o;
        end
        if (bus.rd_data_valid_o === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                check("unexpected_rd_response", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("rd_latency", 64'(cyc - mon_a), 64'(LAT));
                check("rd_addr_err", 64'(bus.rd_addr_err_o), 64'(mon_e.err));
                check("rd_data_set_mismatch_mask", slice_mismatch(bus.rd_data_o, mon_e.data), 64'd0);
            end
        end
    end

    task automatic check_port1_zero(input string tag);
        check({tag, "_p1_enable"}, 64'(bus.port1_enable_o), 64'd0);
        check({tag, "_p1_we"}, 64'(bus.port1_write_enable_o), 64'd0);
        check({tag, "_p1_addr_any"}, 64'(|bus.port1_address_o), 64'd0);
        check({tag, "_p1_wdata_any"}, 64'(|bus.port1_write_data_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ready"}, 64'(bus.wr_ready_o), 64'd0);
        check({tag, "_rd_ready"}, 64'(bus.rd_ready_o), 64'd0);
        check({tag, "_load_done"}, 64'(bus.load_done_o), 64'd0);
        check({tag, "_loaded"}, 64'(bus.loaded_o), 64'd0);
        check({tag, "_rd_data_valid"}, 64'(bus.rd_data_valid_o), 64'd0);
        check({tag, "_rd_addr_err"}, 64'(bus.rd_addr_err_o), 64'd0);
        check({tag, "_rd_data_any"}, 64'(|bus.rd_data_o), 64'd0);
        check_port1_zero(tag);
    endtask

    task automatic stream_words(input int n, input int base, output int acc,
                                output int first, output int last, output int stalls);
        int   guard = 0;
        logic rdy;
        acc = 0; first = -1; last = -1; stalls = 0;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = BW'(base);
        while (acc < n && guard < 2 * n + 20) begin
            @(negedge clk);
            rdy = bus.wr_ready_o;
            if (rdy !== 1'b1) stalls++;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                if (acc == 0) first = cyc - 1;
                last = cyc - 1;
                acc++;
                bus.wr_data_i = BW'(base + acc);
            end
            guard++;
        end
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic do_load(input string tag);
        int acc, first, last, stalls, d0;
        bus.load_start_i = 1'b1;
        @(posedge clk);
        #1 bus.load_start_i = 1'b0;
        d0 = done_cnt;
        stream_words(TOTAL, 0, acc, first, last, stalls);
        check({tag, "_words_accepted"}, 64'(acc), 64'(TOTAL));
        check({tag, "_one_write_per_cycle"}, 64'(last - first + 1), 64'(TOTAL));
        check({tag, "_ready_stalls"}, 64'(stalls), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_done_delay"}, 64'(done_cyc - last), 64'd2);
        check({tag, "_loaded_with_done"}, 64'(done_loaded), 64'd1);
        check({tag, "_loaded"}, 64'(bus.loaded_o), 64'd1);
        check({tag, "_rd_ready"}, 64'(bus.rd_ready_o), 64'd1);
        check({tag, "_wr_ready"}, 64'(bus.wr_ready_o), 64'd0);
    endtask

    task automatic check_contents(input string tag);
        for (int s = 0; s < SN; s++) begin
            int bad = 0;
            for (int a = 0; a < DEPTH; a++)
                if (mem[s][a] !== BW'(DEPTH * s + a)) bad++;
            check($sformatf("%s_set%0d_bad_words", tag, s), 64'(bad), 64'd0);
        end
    endtask

    task automatic send_read(input int addr, input logic exp_err);
        exp_t e;
        e.err  = exp_err;
        e.data = exp_err ? '0 : row_for(addr);
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = AW'(addr);
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.rd_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, first, last, stalls, v0;
        vecs = '{'{0, 1'b0}, '{979, 1'b0}, '{5, 1'b0}, '{1000, 1'b1}, '{1023, 1'b1}, '{978, 1'b0}};

        reset = 1'b1;
        bus.load_start_i = 1'b0;
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = '0;
        bus.rd_valid_i   = 1'b0;
        bus.rd_addr_i    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("idle");

        @(posedge clk);
        #1;
        do_load("load1");
        check_contents("load1");

        // Back-to-back table reads, in-range and out-of-range mixed.
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.err  = vecs[k].exp_err;
            e.data = vecs[k].exp_err ? '0 : row_for(vecs[k].addr);
            bus.rd_valid_i = 1'b1;
            bus.rd_addr_i  = AW'(vecs[k].addr);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.rd_valid_i = 1'b0;
        wait_drain("table_reads");

        send_read(1000, 1'b1);
        @(negedge clk);
        check("err_read_no_enable", 64'(bus.port1_enable_o), 64'd0);
        wait_drain("err_read");

        send_read(5, 1'b0);
        @(negedge clk);
        check("read_all_enable", 64'(bus.port1_enable_o), 64'h3ff);
        check("read_no_write_enable", 64'(bus.port1_write_enable_o), 64'd0);
        check("read_lane9_addr", 64'(bus.port1_address_o[AW*9 +: AW]), 64'd5);
        wait_drain("enable_read");

        // Restart from READY while a read is in flight: response still delivered.
        send_read(7, 1'b0);
        bus.load_start_i = 1'b1;
        @(posedge clk);
        #1 bus.load_start_i = 1'b0;
        @(negedge clk);
        check("restart_loaded_low", 64'(bus.loaded_o), 64'd0);
        check("restart_wr_ready", 64'(bus.wr_ready_o), 64'd1);
        wait_drain("inflight_restart");

        // Restart mid-load with a word offered in the same cycle.
        stream_words(500, 50000, acc, first, last, stalls);
        check("partial_words", 64'(acc), 64'd500);
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = BW'(32'hBAD);
        bus.load_start_i = 1'b1;
        @(negedge clk);
        check("restart_wr_ready_gated", 64'(bus.wr_ready_o), 64'd0);
        @(posedge clk);
        #1 bus.load_start_i = 1'b0;
        bus.wr_data_i = BW'(77777);
        @(negedge clk);
        check("post_restart_wr_ready", 64'(bus.wr_ready_o), 64'd1);
        @(posedge clk);
        #1 bus.wr_valid_i = 1'b0;
        @(negedge clk);
        check("post_restart_p1_enable", 64'(bus.port1_enable_o), 64'd1);
        check("post_restart_p1_we", 64'(bus.port1_write_enable_o), 64'd1);
        check("post_restart_p1_addr0", 64'(bus.port1_address_o[AW-1:0]), 64'd0);
        check("post_restart_p1_wdata0", bus.port1_write_data_o[63:0], 64'd77777);
        @(posedge clk);
        #1;
        check("mem_set0_addr0", mem[0][0][63:0], 64'd77777);
        check("mem_rejected_word", mem[0][500][63:0], 64'd500);
        check("mem_partial_last", mem[0][499][63:0], 64'd50499);

        // Reset while the port1 bus is carrying a write.
        stream_words(20, 60000, acc, first, last, stalls);
        check("pre_reset_p1_active", 64'(bus.port1_enable_o), 64'd1);
        reset = 1'b1;
        #1;
        check_port1_zero("reset_load");
        check("reset_load_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_load");

        @(posedge clk);
        #1;
        do_load("load2");
        check_contents("load2");

        // Reset with a read in flight: the response is dropped.
        send_read(3, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        v0 = valid_cnt;
        #1;
        check_port1_zero("reset_read");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("dropped_response", 64'(valid_cnt - v0), 64'd0);
        check("reset_read_rd_ready", 64'(bus.rd_ready_o), 64'd0);
        check("reset_read_loaded", 64'(bus.loaded_o), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
